inert_spi_resp: RTL and testbench
=================================

// Module: inert_spi_resp
// PURPOSE
// SPI responder (slave) model of the inertial sensor, i.e. the far end of the inertial SPI link.
// Decodes 16-bit mode-0 frames from the SPI monarch, commits config writes, and serves a
//   latched snapshot of ptch/roll/yaw rates and ax/ay over MISO.
// Raises INT when a new snapshot is ready. Used in full-chip sims and as an FPGA sensor stand-in.
// PARAMETERS
// WHO_AM_I   8'h6A   value returned on a read of addr 0x0F
// PORTS
// clk        in   1   50 MHz system clock
// rst_n      in   1   asynchronous active-low reset
// SS_n       in   1   SPI select from monarch, active low
// SCLK       in   1   SPI clock from monarch (slow relative to clk)
// MOSI       in   1   SPI data in, MSB first
// MISO       out  1   SPI data out, MSB first
// INT        out  1   new-snapshot-ready interrupt, active high
// ptch_rt    in   16  pitch-rate sample source (also roll_rt, yaw_rt, ax, ay: 16 each)
// data_strb  in   1   1-clk pulse: new source sample available
// setup_done out  1   high once 0x0D, 0x10, 0x11 and 0x14 have each been written
// BEHAVIOUR
// - Reset: MISO=0, INT=0, setup_done=0, all config regs 8'h00, snapshot regs 0, bit_cnt=0.
// - SS_n/SCLK/MOSI each double-flopped into clk before use; SCLK rise/fall detected on the synced copy.
// - Frame format
//   - SS_n fall: bit_cnt<=0, rx<=0, tx<=0.
//   - Each SCLK rise while SS_n low: rx<={rx[14:0],MOSI}, bit_cnt++ (saturates at 16).
//   - Frame layout: rx[15]=R/W (1=read), rx[14:8]=addr, rx[7:0]=write data.
//   - On the rise making bit_cnt==8: if read, tx<=rdata(addr); else tx<=8'h00.
//   - SCLK falls shift tx left only when bit_cnt is 9..15.
//   - MISO=tx[7] when SS_n low and bit_cnt>=8; else 0. The first 8 MISO bits are always 0.
// - Read map
//   - 0x22/0x23 ptch L/H; 0x24/0x25 roll L/H; 0x26/0x27 yaw L/H; 0x28/0x29 ax L/H; 0x2A/0x2B ay L/H.
//   - 0x0F returns WHO_AM_I; 0x0D/0x10/0x11/0x14 return their config value; all other addrs return 8'h00.
// - Commit: on SS_n rise with bit_cnt==16:
//   - Write: cfg[addr]<=rx[7:0], only for addrs 0x0D/0x10/0x11/0x14; writes to other addrs are ignored.
//   - Read of 0x2B: INT<=0 at the same clk.
//   - SS_n rise with bit_cnt!=16: frame is aborted; nothing is committed and INT is unchanged.
// - Snapshot
//   - data_strb while SS_n synced high: all five sources are latched into snapshot regs at the next clk.
//   - data_strb while SS_n low: set pend; the latch occurs on the clk after SS_n rises, then pend clears.
//   - Snapshot never changes mid-frame, so the 8-bit L/H halves of one burst are always coherent.
//   - On latch: INT<=1 if cfg[0x0D][1]==1; otherwise INT stays 0.
//   - Same-clk latch and 0x2B-read clear: the set wins (INT=1).
// - setup_done is sticky until reset. Writing 0x0D=0x00 later disables future INT sets only.
// - Reset mid-frame: all state returns to reset values; the next SS_n fall starts a clean frame.
// - Latency: snapshot->INT = 1 clk (2 clks when pending). Commit occurs 2-3 clks after the raw SS_n rise.
// TESTING
// 1. Write frames 0x0D02, 0x1062, 0x1162, 0x1460 -> setup_done=1 after the 4th SS_n rise;
//    reads 0x8D00 and 0x9000 return 0x02 and 0x62.
// 2. Sources ptch=0x1234, ay=0xABCD, data_strb after setup -> INT=1;
//    reads A2/A3 return 0x34/0x12; read AB returns 0xAB; INT=0 after that frame.
// 3. data_strb pulse mid-frame with new ptch=0x5555 -> in-progress frame returns the old byte;
//    latch and INT follow the SS_n rise.
// 4. Frame aborted after 10 SCLKs (write 0x10FF) -> cfg 0x10 unchanged; INT unchanged.
// 5. Read 0x8F00 -> MISO shows 0x6A in bits 7:0; read 0xC500 -> 0x00.
// 6. Without writing 0x0D, data_strb -> INT stays 0; assert rst_n low mid-read -> all outputs return to 0.

Source files
------------

// File: rtl/inert_spi_if.sv
// SPI link and sensor-source bundle between the inertial responder and its
// surroundings. The master side is the SPI monarch plus the sample source; the
// slave side is the responder itself.
interface inert_spi_if;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        INT;
    logic [15:0] ptch_rt;
    logic [15:0] roll_rt;
    logic [15:0] yaw_rt;
    logic [15:0] ax;
    logic [15:0] ay;
    logic        data_strb;
    logic        setup_done;

    modport master (
        output SS_n, SCLK, MOSI,
        output ptch_rt, roll_rt, yaw_rt, ax, ay, data_strb,
        input  MISO, INT, setup_done
    );

    modport slave (
        input  SS_n, SCLK, MOSI,
        input  ptch_rt, roll_rt, yaw_rt, ax, ay, data_strb,
        output MISO, INT, setup_done
    );
endinterface

// File: rtl/inert_spi_resp.sv
// Inertial sensor SPI responder model. Decodes 16-bit mode-0 frames, keeps four
// config registers, and serves a coherent snapshot of the five rate/accel
// sources. INT flags a fresh snapshot and is cleared by reading the ay high byte.
module inert_spi_resp #(
    parameter logic [7:0] WHO_AM_I = 8'h6A
) (
    input  logic        clk,
    input  logic        rst_n,
    inert_spi_if.slave  spi
);

    localparam logic [6:0] ADDR_CTRL  = 7'h0D;
    localparam logic [6:0] ADDR_WHO   = 7'h0F;
    localparam logic [6:0] ADDR_CFG10 = 7'h10;
    localparam logic [6:0] ADDR_CFG11 = 7'h11;
    localparam logic [6:0] ADDR_CFG14 = 7'h14;
    localparam logic [6:0] ADDR_AY_H  = 7'h2B;
    localparam logic [4:0] CNT_FULL   = 5'd16;

    // synchronisers and edge-detect history
    logic        ss_meta_q,   ss_sync_q,   ss_prev_q;
    logic        sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic        mosi_meta_q, mosi_sync_q;

    // frame state
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] rx_q,      rx_d;
    logic [7:0]  tx_q,      tx_d;

    // config registers and first-write flags
    logic [7:0]  cfg_0d_q, cfg_10_q, cfg_11_q, cfg_14_q;
    logic        wr_0d_q,  wr_10_q,  wr_11_q,  wr_14_q;

    // snapshot registers
    logic [15:0] snap_ptch_q, snap_roll_q, snap_yaw_q, snap_ax_q, snap_ay_q;
    logic        pend_q;

    // registered outputs
    logic        miso_q;
    logic        int_q;
    logic        setup_done_q;

    // decoded events
    logic        ss_fall_s, ss_rise_s, ss_low_s;
    logic        sclk_rise_s, sclk_fall_s;
    logic        commit_s, cmd_rd_s;
    logic [6:0]  cmd_addr_s;
    logic        lookup_rd_s;
    logic [6:0]  lookup_addr_s;
    logic [7:0]  rdata_s;
    logic        latch_s;
    logic        shift_win_s;

    assign ss_low_s    = ~ss_sync_q;
    assign ss_fall_s   =  ss_prev_q   & ~ss_sync_q;
    assign ss_rise_s   = ~ss_prev_q   &  ss_sync_q;
    assign sclk_rise_s =  sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall_s = ~sclk_sync_q &  sclk_prev_q;

    // The command byte is complete on the rise that takes bit_cnt to 8; the
    // lookup address is formed from the bits already held plus the incoming bit
    // so the read data is ready on that same clk.
    assign lookup_rd_s   = rx_q[6];
    assign lookup_addr_s = {rx_q[5:0], mosi_sync_q};

    assign cmd_rd_s    = rx_q[15];
    assign cmd_addr_s  = rx_q[14:8];
    assign commit_s    = ss_rise_s & (bit_cnt_q == CNT_FULL);
    assign shift_win_s = (bit_cnt_q >= 5'd9) & (bit_cnt_q <= 5'd15);

    // A sample is only ever taken while the select is idle, so one frame always
    // sees one snapshot; a strobe that arrives mid-frame is deferred via pend_q.
    assign latch_s = ss_sync_q & (spi.data_strb | pend_q);

    // Bring SS_n/SCLK/MOSI into the clk domain and keep one cycle of history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_meta_q   <= 1'b1;
            ss_sync_q   <= 1'b1;
            ss_prev_q   <= 1'b1;
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            ss_meta_q   <= spi.SS_n;
            ss_sync_q   <= ss_meta_q;
            ss_prev_q   <= ss_sync_q;
            sclk_meta_q <= spi.SCLK;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            mosi_meta_q <= spi.MOSI;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    // Read mux for the addressed register.
    always_comb begin
        rdata_s = 8'h00;
        case (lookup_addr_s)
            ADDR_CTRL:  rdata_s = cfg_0d_q;
            ADDR_WHO:   rdata_s = WHO_AM_I;
            ADDR_CFG10: rdata_s = cfg_10_q;
            ADDR_CFG11: rdata_s = cfg_11_q;
            ADDR_CFG14: rdata_s = cfg_14_q;
            7'h22:      rdata_s = snap_ptch_q[7:0];
            7'h23:      rdata_s = snap_ptch_q[15:8];
            7'h24:      rdata_s = snap_roll_q[7:0];
            7'h25:      rdata_s = snap_roll_q[15:8];
            7'h26:      rdata_s = snap_yaw_q[7:0];
            7'h27:      rdata_s = snap_yaw_q[15:8];
            7'h28:      rdata_s = snap_ax_q[7:0];
            7'h29:      rdata_s = snap_ax_q[15:8];
            7'h2A:      rdata_s = snap_ay_q[7:0];
            7'h2B:      rdata_s = snap_ay_q[15:8];
            default:    rdata_s = 8'h00;
        endcase
    end

    // Next-state for the shift registers and bit counter.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        if (ss_fall_s) begin
            bit_cnt_d = 5'd0;
            rx_d      = 16'h0000;
            tx_d      = 8'h00;
        end else if (ss_low_s && sclk_rise_s) begin
            rx_d = {rx_q[14:0], mosi_sync_q};
            if (bit_cnt_q != CNT_FULL) begin
                bit_cnt_d = bit_cnt_q + 5'd1;
            end else begin
                bit_cnt_d = bit_cnt_q;
            end
            if (bit_cnt_q == 5'd7) begin
                if (lookup_rd_s) begin
                    tx_d = rdata_s;
                end else begin
                    tx_d = 8'h00;
                end
            end else begin
                tx_d = tx_q;
            end
        end else if (ss_low_s && sclk_fall_s && shift_win_s) begin
            tx_d = {tx_q[6:0], 1'b0};
        end else begin
            tx_d = tx_q;
        end
    end

    // Frame state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= 5'd0;
            rx_q      <= 16'h0000;
            tx_q      <= 8'h00;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
        end
    end

    // Commit complete write frames into the config registers that exist.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_0d_q <= 8'h00;
            cfg_10_q <= 8'h00;
            cfg_11_q <= 8'h00;
            cfg_14_q <= 8'h00;
            wr_0d_q  <= 1'b0;
            wr_10_q  <= 1'b0;
            wr_11_q  <= 1'b0;
            wr_14_q  <= 1'b0;
        end else if (commit_s && !cmd_rd_s) begin
            case (cmd_addr_s)
                ADDR_CTRL: begin
                    cfg_0d_q <= rx_q[7:0];
                    wr_0d_q  <= 1'b1;
                end
                ADDR_CFG10: begin
                    cfg_10_q <= rx_q[7:0];
                    wr_10_q  <= 1'b1;
                end
                ADDR_CFG11: begin
                    cfg_11_q <= rx_q[7:0];
                    wr_11_q  <= 1'b1;
                end
                ADDR_CFG14: begin
                    cfg_14_q <= rx_q[7:0];
                    wr_14_q  <= 1'b1;
                end
                default: begin
                    cfg_0d_q <= cfg_0d_q;
                end
            endcase
        end
    end

    // setup_done goes high once all four config registers have been written, and stays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            setup_done_q <= 1'b0;
        end else begin
            setup_done_q <= setup_done_q | (wr_0d_q & wr_10_q & wr_11_q & wr_14_q);
        end
    end

    // Remember a strobe that arrived while a frame was in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
        end else if (latch_s) begin
            pend_q <= 1'b0;
        end else if (spi.data_strb && ss_low_s) begin
            pend_q <= 1'b1;
        end
    end

    // Capture all five sources together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_ptch_q <= 16'h0000;
            snap_roll_q <= 16'h0000;
            snap_yaw_q  <= 16'h0000;
            snap_ax_q   <= 16'h0000;
            snap_ay_q   <= 16'h0000;
        end else if (latch_s) begin
            snap_ptch_q <= spi.ptch_rt;
            snap_roll_q <= spi.roll_rt;
            snap_yaw_q  <= spi.yaw_rt;
            snap_ax_q   <= spi.ax;
            snap_ay_q   <= spi.ay;
        end
    end

    // INT: set by an enabled latch, cleared by a complete read of the ay high byte; set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_q <= 1'b0;
        end else if (latch_s && cfg_0d_q[1]) begin
            int_q <= 1'b1;
        end else if (commit_s && cmd_rd_s && (cmd_addr_s == ADDR_AY_H)) begin
            int_q <= 1'b0;
        end
    end

    // MISO drives the data byte only in the second half of a selected frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_q <= 1'b0;
        end else if (ss_low_s && (bit_cnt_q >= 5'd8)) begin
            miso_q <= tx_q[7];
        end else begin
            miso_q <= 1'b0;
        end
    end

    assign spi.MISO       = miso_q;
    assign spi.INT        = int_q;
    assign spi.setup_done = setup_done_q;

endmodule

// File: tb/tb_inert_spi_resp.sv
// Randomised self-checking bench for inert_spi_resp against a register-map level model.
module tb_inert_spi_resp;

    localparam int HALF = 6;   // clk cycles per SCLK half period

    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    inert_spi_if u_if();

    inert_spi_resp #(.WHO_AM_I(8'h6A)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .spi   (u_if)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    logic [7:0]  m_cfg [4];      // 0x0D, 0x10, 0x11, 0x14
    logic        m_wr  [4];
    logic [15:0] m_snap[5];      // ptch, roll, yaw, ax, ay
    logic [15:0] src   [5];
    logic        m_int;
    logic        m_setup;

    function automatic int cfg_idx(input logic [6:0] a);
        case (a)
            7'h0D:   return 0;
            7'h10:   return 1;
            7'h11:   return 2;
            7'h14:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] m_read(input logic [6:0] a);
        int off;
        off = int'(a) - 34;
        if (off >= 0 && off <= 9)
            return (off % 2 == 1) ? m_snap[off / 2][15:8] : m_snap[off / 2][7:0];
        if (a == 7'h0F) return 8'h6A;
        if (cfg_idx(a) >= 0) return m_cfg[cfg_idx(a)];
        return 8'h00;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin m_cfg[i] = 8'h00; m_wr[i] = 1'b0; end
        for (int i = 0; i < 5; i++) m_snap[i] = 16'h0000;
        m_int = 1'b0;
        m_setup = 1'b0;
    endtask

    task automatic m_commit(input logic [15:0] w);
        if (w[15]) begin
            if (w[14:8] == 7'h2B) m_int = 1'b0;
        end else if (cfg_idx(w[14:8]) >= 0) begin
            m_cfg[cfg_idx(w[14:8])] = w[7:0];
            m_wr[cfg_idx(w[14:8])]  = 1'b1;
            if (m_wr[0] && m_wr[1] && m_wr[2] && m_wr[3]) m_setup = 1'b1;
        end
    endtask

    task automatic m_latch();
        for (int i = 0; i < 5; i++) m_snap[i] = src[i];
        if (m_cfg[0][1]) m_int = 1'b1;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive_sources();
        u_if.ptch_rt = src[0];
        u_if.roll_rt = src[1];
        u_if.yaw_rt  = src[2];
        u_if.ax      = src[3];
        u_if.ay      = src[4];
    endtask

    task automatic random_sources();
        for (int i = 0; i < 5; i++) src[i] = 16'($urandom);
        drive_sources();
    endtask

    // One strobe while the select is idle.
    task automatic strobe();
        @(negedge clk) u_if.data_strb = 1'b1;
        @(negedge clk) u_if.data_strb = 1'b0;
        @(negedge clk);
        m_latch();
    endtask

    // One SPI frame of nbits; optionally pulse data_strb during bit strb_at.
    task automatic spi_frame(input logic [15:0] word, input int nbits, input int strb_at,
                             output logic [15:0] got);
        got = 16'h0000;
        @(negedge clk) u_if.SS_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            u_if.MOSI = word[15 - i];
            repeat (HALF) @(negedge clk);
            u_if.SCLK = 1'b1;
            got = {got[14:0], u_if.MISO};
            if (i == strb_at) begin
                u_if.data_strb = 1'b1;
                @(negedge clk) u_if.data_strb = 1'b0;
                repeat (HALF - 1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            u_if.SCLK = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        u_if.SS_n = 1'b1;
        u_if.MOSI = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        if (nbits == 16) m_commit(word);
        if (strb_at >= 0) m_latch();
    endtask

    // Full read of addr a, compared against the model's view before the frame.
    task automatic check_read(input logic [6:0] a, input string name);
        logic [15:0] got, exp;
        exp = {8'h00, m_read(a)};
        spi_frame({1'b1, a, 8'h00}, 16, -1, got);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s addr=%h got=%h exp=%h", name, a, got, exp);
        end
    endtask

    task automatic check_outputs(input string name);
        checks++;
        if (u_if.INT !== m_int || u_if.setup_done !== m_setup) begin
            errors++;
            $display("FAIL %s INT=%b exp=%b setup_done=%b exp=%b",
                     name, u_if.INT, m_int, u_if.setup_done, m_setup);
        end
    endtask

    task automatic write_reg(input logic [6:0] a, input logic [7:0] d);
        logic [15:0] got;
        spi_frame({1'b0, a, d}, 16, -1, got);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        u_if.SS_n = 1'b1; u_if.SCLK = 1'b0; u_if.MOSI = 1'b0; u_if.data_strb = 1'b0;
        for (int i = 0; i < 5; i++) src[i] = 16'h0000;
        drive_sources();
        m_reset();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (u_if.MISO !== 1'b0 || u_if.INT !== 1'b0 || u_if.setup_done !== 1'b0) begin
            errors++;
            $display("FAIL reset MISO=%b INT=%b setup_done=%b exp=0", u_if.MISO, u_if.INT, u_if.setup_done);
        end
        check_read(7'h0D, "reset_cfg0d");
        check_read(7'h22, "reset_snap");
    endtask

    task automatic test_no_int_without_enable();
        random_sources();
        strobe();
        check_outputs("no_enable_int");
        check_read(7'h22, "no_enable_snap_l");
        check_read(7'h2B, "no_enable_snap_h");
    endtask

    task automatic test_setup();
        logic [15:0] frames [4];
        frames = '{16'h0D02, 16'h1062, 16'h1162, 16'h1460};
        for (int i = 0; i < 4; i++) begin
            write_reg(frames[i][14:8], frames[i][7:0]);
            check_outputs($sformatf("setup_step%0d", i));
        end
        check_read(7'h0D, "setup_rd_0d");
        check_read(7'h10, "setup_rd_10");
    endtask

    task automatic test_snapshot();
        for (int it = 0; it < 3; it++) begin
            random_sources();
            if (it == 0) begin src[0] = 16'h1234; src[4] = 16'hABCD; drive_sources(); end
            strobe();
            check_outputs($sformatf("snap_int_set%0d", it));
            for (int a = 34; a <= 42; a++) check_read(7'(a), "snap_rd");
            check_outputs($sformatf("snap_int_held%0d", it));
            check_read(7'h2B, "snap_rd_ay_h");
            check_outputs($sformatf("snap_int_clear%0d", it));
        end
    endtask

    task automatic test_pending();
        logic [15:0] got, exp;
        random_sources();
        src[0] = 16'h5555;
        drive_sources();
        exp = {8'h00, m_read(7'h22)};
        spi_frame(16'hA200, 16, 4, got);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL pending_old_byte got=%h exp=%h", got, exp);
        end
        check_outputs("pending_int_after");
        check_read(7'h22, "pending_new_l");
        random_sources();
        exp = {8'h00, m_read(7'h2B)};
        spi_frame(16'hAB00, 16, 10, got);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL pending_ay_h got=%h exp=%h", got, exp);
        end
        check_outputs("pending_set_wins");
    endtask

    task automatic test_abort();
        logic [15:0] got;
        spi_frame(16'h10FF, 10, -1, got);
        check_read(7'h10, "abort_cfg10");
        check_outputs("abort_int_kept");
        spi_frame(16'hAB00, 12, -1, got);
        check_outputs("abort_read_int_kept");
    endtask

    task automatic test_map();
        logic [6:0] a;
        check_read(7'h0F, "whoami");
        check_read(7'h45, "unmapped_c5");
        for (int i = 0; i < 6; i++) begin
            do a = 7'($urandom_range(0, 127));
            while (cfg_idx(a) >= 0 || (a >= 7'h22 && a <= 7'h2B) || a == 7'h0F);
            write_reg(a, 8'($urandom));
            check_read(a, "unmapped_rnd");
        end
        for (int i = 0; i < 3; i++) begin
            write_reg(7'h11, 8'($urandom));
            check_read(7'h11, "cfg11_rnd");
        end
    endtask

    task automatic test_disable();
        check_read(7'h2B, "disable_clear");
        write_reg(7'h0D, 8'h00);
        random_sources();
        strobe();
        check_outputs("disable_no_int");
        check_read(7'h24, "disable_snap");
    endtask

    task automatic test_reset_midframe();
        write_reg(7'h0D, 8'h02);
        random_sources();
        strobe();
        check_outputs("midreset_pre");
        @(negedge clk) u_if.SS_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            u_if.MOSI = (i == 0 || i >= 5) ? 1'b1 : 1'b0;
            repeat (HALF) @(negedge clk);
            u_if.SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
            u_if.SCLK = 1'b0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (u_if.MISO !== 1'b0 || u_if.INT !== 1'b0 || u_if.setup_done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs MISO=%b INT=%b setup_done=%b exp=0",
                     u_if.MISO, u_if.INT, u_if.setup_done);
        end
        u_if.SS_n = 1'b1;
        u_if.MOSI = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_read(7'h0D, "midreset_cfg0d");
        check_read(7'h0F, "midreset_whoami");
        check_outputs("midreset_post");
    endtask

    initial begin
        test_reset();
        test_no_int_without_enable();
        test_setup();
        test_snapshot();
        test_pending();
        test_abort();
        test_map();
        test_disable();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
